// File: rtl/pve_l1_pkg.sv
// Shared types and constants for the PVE L1 bank arbitration slice.
// Provides the bank address type, the requester index type, the default
// bank read latency, the response pipeline entry type and a wrap-around
// increment helper used by the round-robin pointer.
package pve_l1_pkg;

  localparam int PVE_L1_ADDR_W             = 12;
  localparam int PVE_L1_IDX_W              = 4;   // covers up to 16 requesters
  localparam int PVE_L1_BANK_READ_LATENCY  = 2;

  typedef logic [PVE_L1_ADDR_W-1:0] pve_l1_bank_addr_t;
  typedef logic [PVE_L1_IDX_W-1:0]  pve_l1_req_idx_t;

  // One in-flight access: who asked and whether data comes back.
  typedef struct packed {
    logic            valid;
    logic            we;
    pve_l1_req_idx_t id;
  } pve_l1_rsp_stage_t;

  // Next index after idx, wrapping from num-1 back to 0.
  function automatic pve_l1_req_idx_t pve_l1_wrap_inc(input pve_l1_req_idx_t idx,
                                                      input int unsigned     num);
    pve_l1_req_idx_t next_idx;
    if ((32'(idx) + 32'd1) >= num) begin
      next_idx = '0;
    end else begin
      next_idx = idx + 4'd1;
    end
    return next_idx;
  endfunction

endpackage

// File: rtl/pve_l1_rr_arb.sv
// Round-robin picker with a forced-index override and its pointer register.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   req_valid    per-requester request valid
//   force_en     when set, force_idx wins regardless of the pointer
//   force_idx    index granted under force_en
//   grant        one-hot grant (all zero when nothing is valid)
//   grant_idx    binary index of the grant (0 when no grant)
//   grant_any    at least one grant this cycle
module pve_l1_rr_arb
  import pve_l1_pkg::*;
#(
  parameter int NumReq = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NumReq-1:0]     req_valid,
  input  logic                  force_en,
  input  pve_l1_req_idx_t       force_idx,
  output logic [NumReq-1:0]     grant,
  output pve_l1_req_idx_t       grant_idx,
  output logic                  grant_any
);

  pve_l1_req_idx_t ptr_r;
  logic [15:0]     valid_pad_s;
  logic [15:0]     grant_pad_s;
  logic [4:0]      cand_s;
  logic            pick_any_s;
  pve_l1_req_idx_t pick_idx_s;

  // Scan from the pointer for the first valid requester, then apply the override.
  always_comb begin
    valid_pad_s = 16'(req_valid);
    pick_any_s  = 1'b0;
    pick_idx_s  = '0;
    cand_s      = 5'd0;
    for (int i = 0; i < NumReq; i++) begin
      cand_s = {1'b0, ptr_r} + 5'(i);
      if (cand_s >= 5'(NumReq)) begin
        cand_s = cand_s - 5'(NumReq);
      end else begin
        cand_s = cand_s;
      end
      if (!pick_any_s && valid_pad_s[cand_s[3:0]]) begin
        pick_any_s = 1'b1;
        pick_idx_s = cand_s[3:0];
      end else begin
        pick_any_s = pick_any_s;
      end
    end
    if (force_en) begin
      grant_any = 1'b1;
      grant_idx = force_idx;
    end else begin
      grant_any = pick_any_s;
      grant_idx = pick_idx_s;
    end
    if (grant_any) begin
      grant_pad_s = 16'd1 << grant_idx;
    end else begin
      grant_pad_s = 16'd0;
    end
    grant = grant_pad_s[NumReq-1:0];
  end

  // Pointer moves just past whoever won, including a forced winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (grant_any) begin
      ptr_r <= pve_l1_wrap_inc(grant_idx, NumReq);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/pve_l1_bank_arbiter.sv
// Per-bank arbiter between the L1 requesters (RVV ports plus the DMC port)
// and one single-ported SRAM bank. Grants at most one request per cycle,
// round-robin with an aging override for HiPrioIdx, and returns a one-hot
// acknowledge ReadLatency cycles after each grant.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_starve_limit            aging threshold for HiPrioIdx (0 = off)
//   i_req_valid/addr/we/be/wdata  per-requester request, packed by index
//   o_req_ready               one-hot grant
//   o_rsp_valid, o_rsp_rdata  one-hot acknowledge and shared read data
//   o_mem_*                   bank access for the granted request
//   i_mem_rdata               bank read data, ReadLatency after the read
module pve_l1_bank_arbiter
  import pve_l1_pkg::*;
#(
  parameter int NumReq      = 5,
  parameter int HiPrioIdx   = 4,
  parameter int AddrW       = 12,
  parameter int DataW       = 512,
  parameter int ReadLatency = PVE_L1_BANK_READ_LATENCY,
  parameter int StarveW     = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [StarveW-1:0]        i_starve_limit,
  input  logic [NumReq-1:0]         i_req_valid,
  input  logic [NumReq*AddrW-1:0]   i_req_addr,
  input  logic [NumReq-1:0]         i_req_we,
  input  logic [NumReq*DataW/8-1:0] i_req_be,
  input  logic [NumReq*DataW-1:0]   i_req_wdata,
  output logic [NumReq-1:0]         o_req_ready,
  output logic [NumReq-1:0]         o_rsp_valid,
  output logic [DataW-1:0]          o_rsp_rdata,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [AddrW-1:0]          o_mem_addr,
  output logic [DataW/8-1:0]        o_mem_be,
  output logic [DataW-1:0]          o_mem_wdata,
  input  logic [DataW-1:0]          i_mem_rdata
);

  localparam int BeW       = DataW / 8;
  localparam int LastStage = ReadLatency - 1;

  logic [NumReq-1:0]  valid_s;
  logic               hp_valid_s;
  logic               force_s;
  logic [StarveW-1:0] age_r;
  logic [NumReq-1:0]  grant_s;
  pve_l1_req_idx_t    grant_idx_s;
  logic               grant_any_s;
  pve_l1_rsp_stage_t  rsp_pipe_r [ReadLatency];
  pve_l1_rsp_stage_t  rsp_last_s;

  // Requests are masked while reset is asserted so every output reads zero.
  assign valid_s    = i_req_valid & {NumReq{i_rst_n}};
  assign hp_valid_s = valid_s[HiPrioIdx];
  assign force_s    = (i_starve_limit != '0) && hp_valid_s && (age_r >= i_starve_limit);

  pve_l1_rr_arb #(
    .NumReq (NumReq)
  ) u_rr_arb (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .req_valid (valid_s),
    .force_en  (force_s),
    .force_idx (PVE_L1_IDX_W'(HiPrioIdx)),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // AND-OR mux of the granted request onto the bank port.
  always_comb begin
    o_req_ready = grant_s;
    o_mem_req   = grant_any_s;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_be    = '0;
    o_mem_wdata = '0;
    for (int k = 0; k < NumReq; k++) begin
      o_mem_we    = o_mem_we    | (i_req_we[k] & grant_s[k]);
      o_mem_addr  = o_mem_addr  | (i_req_addr[k*AddrW +: AddrW] & {AddrW{grant_s[k]}});
      o_mem_be    = o_mem_be    | (i_req_be[k*BeW +: BeW] & {BeW{grant_s[k]}});
      o_mem_wdata = o_mem_wdata | (i_req_wdata[k*DataW +: DataW] & {DataW{grant_s[k]}});
    end
  end

  // Aging: count consecutive waiting cycles of the priority port, saturating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      age_r <= '0;
    end else if (!hp_valid_s || grant_s[HiPrioIdx]) begin
      age_r <= '0;
    end else if (age_r != {StarveW{1'b1}}) begin
      age_r <= age_r + StarveW'(1);
    end else begin
      age_r <= age_r;
    end
  end

  // Fixed-latency tracker of in-flight grants; writes ride along so order holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < ReadLatency; s++) begin
        rsp_pipe_r[s] <= '0;
      end
    end else begin
      rsp_pipe_r[0] <= '{valid: grant_any_s, we: o_mem_we, id: grant_idx_s};
      for (int s = 1; s < ReadLatency; s++) begin
        rsp_pipe_r[s] <= rsp_pipe_r[s-1];
      end
    end
  end

  assign rsp_last_s = rsp_pipe_r[LastStage];

  // Decode the last stage into the one-hot acknowledge and gate read data.
  always_comb begin
    o_rsp_valid = '0;
    for (int k = 0; k < NumReq; k++) begin
      o_rsp_valid[k] = rsp_last_s.valid && (rsp_last_s.id == PVE_L1_IDX_W'(k));
    end
    if (rsp_last_s.valid && !rsp_last_s.we) begin
      o_rsp_rdata = i_mem_rdata;
    end else begin
      o_rsp_rdata = '0;
    end
  end

endmodule

// File: tb/tb_pve_l1_bank_arbiter.sv
// Directed bench for pve_l1_bank_arbiter with a small 2-cycle SRAM model.
module tb_pve_l1_bank_arbiter;

  localparam int N  = 5;
  localparam int AW = 12;
  localparam int DW = 512;
  localparam int BW = DW / 8;

  logic            clk;
  logic            rst_n;
  logic [3:0]      starve_limit;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_we;
  logic [N*BW-1:0] req_be;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [BW-1:0]   mem_be;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] rd_q1;
  logic [DW-1:0] rd_q2;
  logic [DW-1:0] pat_a5;
  logic [4:0]    exp_age [8];

  pve_l1_bank_arbiter dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_starve_limit (starve_limit),
    .i_req_valid    (req_valid),
    .i_req_addr     (req_addr),
    .i_req_we       (req_we),
    .i_req_be       (req_be),
    .i_req_wdata    (req_wdata),
    .o_req_ready    (req_ready),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_mem_req      (mem_req),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_be       (mem_be),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'hC0DE_0000 | {20'd0, a};
    return {16{w}};
  endfunction

  // SRAM model: byte-enabled writes, reads return two cycles later.
  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      for (int b = 0; b < BW; b++) begin
        if (mem_be[b]) mem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    rd_q1 <= (mem_req && !mem_we) ? mem[mem_addr[5:0]] : '0;
    rd_q2 <= rd_q1;
  end
  assign mem_rdata = rd_q2;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic we, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
    req_we[k]             = we;
    req_addr[k*AW +: AW]  = a;
    req_be[k*BW +: BW]    = be;
    req_wdata[k*DW +: DW] = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    starve_limit = 4'd0;
    req_valid    = '1;
    req_addr     = '0;
    req_we       = '0;
    req_be       = '0;
    req_wdata    = '0;
    rd_q1        = '0;
    rd_q2        = '0;
    pat_a5       = {64{8'hA5}};
    for (int i = 0; i < 64; i++) mem[i] = memval(AW'(i));
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 12'h010 + AW'(k), '1, {64{8'h3C}});
    exp_age = '{5'b00001, 5'b00010, 5'b00100, 5'b10000,
                5'b00001, 5'b00010, 5'b00100, 5'b10000};

    // Reset state with all requesters valid.
    #4;
    check_eq("rst_ready", DW'(req_ready), '0);
    check_eq("rst_mem_req", DW'(mem_req), '0);
    check_eq("rst_mem_addr", DW'(mem_addr), '0);
    check_eq("rst_mem_wdata", mem_wdata, '0);
    check_eq("rst_rsp_valid", DW'(rsp_valid), '0);
    next_cycle();
    next_cycle();
    rst_n     = 1'b1;
    req_valid = '0;
    #3;
    check_eq("idle_after_rst", DW'(mem_req), '0);

    // Requesters 0 and 2 alternate; reads of 0x010 / 0x011.
    set_req(0, 1'b0, 12'h010, '1, '0);
    set_req(2, 1'b0, 12'h011, '1, '0);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      req_valid = (k < 6) ? 5'b00101 : 5'b00000;
      #3;
      if (k < 6) check_eq($sformatf("rr_grant%0d", k), DW'(req_ready),
                          DW'((k % 2 == 0) ? 5'b00001 : 5'b00100));
      if (k == 0) check_eq("rr_addr0", DW'(mem_addr), DW'(12'h010));
      if (k >= 2) begin
        check_eq($sformatf("rr_rsp%0d", k), DW'(rsp_valid),
                 DW'((k % 2 == 0) ? 5'b00001 : 5'b00100));
        check_eq($sformatf("rr_rdata%0d", k), rsp_rdata,
                 memval((k % 2 == 0) ? 12'h010 : 12'h011));
      end
    end

    // Idle: no bank access, pointer kept (last winner 2, so 3 is next).
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      req_valid = '0;
      #3;
      check_eq($sformatf("idle_mem_req%0d", i), DW'(mem_req), '0);
      check_eq($sformatf("idle_rsp%0d", i), DW'(rsp_valid), '0);
    end
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 12'h010 + AW'(k), '1, '0);
    next_cycle();
    req_valid = 5'b01011;
    #3;
    check_eq("idle_ptr_kept", DW'(req_ready), DW'(5'b01000));

    // Two grants, then reset: in-flight responses must vanish.
    next_cycle();
    req_valid = 5'b11111;
    #3;
    check_eq("pre_rst_g4", DW'(req_ready), DW'(5'b10000));
    next_cycle();
    #3;
    check_eq("pre_rst_g0", DW'(req_ready), DW'(5'b00001));
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      rst_n = 1'b0;
      #3;
      check_eq($sformatf("mid_rst_ready%0d", i), DW'(req_ready), '0);
      check_eq($sformatf("mid_rst_rsp%0d", i), DW'(rsp_valid), '0);
      check_eq($sformatf("mid_rst_memreq%0d", i), DW'(mem_req), '0);
    end
    next_cycle();
    rst_n     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      #3;
      check_eq($sformatf("post_rst_rsp%0d", i), DW'(rsp_valid), '0);
      next_cycle();
    end

    // Aging with limit 3: requester 4 forced on its 4th waiting cycle.
    starve_limit = 4'd3;
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 5'b11111 : 5'b00000;
      #3;
      if (k < 8) check_eq($sformatf("age_grant%0d", k), DW'(req_ready), DW'(exp_age[k]));
      if (k == 3) check_eq("age_addr", DW'(mem_addr), DW'(12'h014));
      if (k >= 2) check_eq($sformatf("age_rsp%0d", k), DW'(rsp_valid), DW'(exp_age[k-2]));
      next_cycle();
    end
    starve_limit = 4'd0;
    req_valid    = '0;

    // Write 0x020 from req 1, then read it back from req 3.
    next_cycle();
    set_req(1, 1'b1, 12'h020, '1, pat_a5);
    req_valid = 5'b00010;
    #3;
    check_eq("wr_ready", DW'(req_ready), DW'(5'b00010));
    check_eq("wr_mem_we", DW'(mem_we), DW'(1'b1));
    check_eq("wr_mem_be", DW'(mem_be), DW'({BW{1'b1}}));
    check_eq("wr_mem_wdata", mem_wdata, pat_a5);
    next_cycle();
    set_req(3, 1'b0, 12'h020, '1, '0);
    req_valid = 5'b01000;
    #3;
    check_eq("rd_ready", DW'(req_ready), DW'(5'b01000));
    check_eq("rd_mem_we", DW'(mem_we), '0);
    next_cycle();
    req_valid = '0;
    #3;
    check_eq("wr_ack", DW'(rsp_valid), DW'(5'b00010));
    check_eq("wr_ack_rdata", rsp_rdata, '0);
    next_cycle();
    #3;
    check_eq("rd_ack", DW'(rsp_valid), DW'(5'b01000));
    check_eq("rd_ack_rdata", rsp_rdata, pat_a5);

    // Single requester streaming for 20 cycles: no bubbles.
    set_req(2, 1'b0, 12'h010, '1, '0);
    for (int k = 0; k < 23; k++) begin
      next_cycle();
      req_valid = (k < 20) ? 5'b00100 : 5'b00000;
      #3;
      if (k < 20) check_eq($sformatf("stream_grant%0d", k), DW'(req_ready), DW'(5'b00100));
      if (k >= 2 && k < 22) begin
        check_eq($sformatf("stream_rsp%0d", k), DW'(rsp_valid), DW'(5'b00100));
        check_eq($sformatf("stream_rdata%0d", k), rsp_rdata, memval(12'h010));
      end
      if (k == 22) check_eq("stream_end", DW'(rsp_valid), '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
